// File: rtl/adder_sum_decoder.sv
// adder_sum_decoder: bit-serial recovery of x = sm - y - cin behind an adder lane.
// One bit of the difference is produced per clock, LSB first; flags borrow and zero result.
// Optional feature macro: ADDER_SUM_DECODER_OVF_EN adds the ovf output (x does not fit WIDTH bits).
module adder_sum_decoder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SWIDTH = WIDTH + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SWIDTH-1:0] sm,
  input  logic [WIDTH-1:0]  y,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  x,
  output logic              x_zero,
  output logic              borrow
`ifdef ADDER_SUM_DECODER_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int unsigned CW = (SWIDTH > 1) ? $clog2(SWIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SWIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CW-1:0]     cnt;
  logic [SWIDTH-1:0] a_q;
  logic [SWIDTH-1:0] b_q;
  logic              br_q;
  // Difference bits produced so far; the final (MSB) bit is taken live from d_c.
  logic [SWIDTH-2:0] diff_q;

  logic d_c;
  logic br_nxt_c;
  logic last_c;
  logic accept_c;

  // One full-subtractor step on the current LSBs plus handshake/terminal decode.
  always_comb begin
    d_c      = a_q[0] ^ b_q[0] ^ br_q;
    br_nxt_c = (~a_q[0] & (b_q[0] | br_q)) | (b_q[0] & br_q);
    last_c   = (cnt == CNT_LAST);
    accept_c = in_valid & in_ready;
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after last bit, DONE -> IDLE on consume.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_c)  state_nxt = S_RUN;
      S_RUN:   if (last_c)    state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; handshake outputs registered as a decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == S_IDLE);
      out_valid <= (state_nxt == S_DONE);
    end
  end

  // Operand capture, serial shift datapath and result registers loaded on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      diff_q <= '0;
      x      <= '0;
      x_zero <= 1'b0;
      borrow <= 1'b0;
`ifdef ADDER_SUM_DECODER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept_c) begin
      a_q    <= sm;
      b_q    <= SWIDTH'(y);
      br_q   <= cin;
      cnt    <= '0;
      diff_q <= '0;
    end else if (state == S_RUN) begin
      a_q    <= a_q >> 1;
      b_q    <= b_q >> 1;
      br_q   <= br_nxt_c;
      diff_q <= {d_c, diff_q[SWIDTH-2:1]};
      cnt    <= cnt + CW'(1);
      if (last_c) begin
        x      <= diff_q[WIDTH-1:0];
        x_zero <= (diff_q[WIDTH-1:0] == '0);
        borrow <= br_nxt_c;
`ifdef ADDER_SUM_DECODER_OVF_EN
        ovf    <= d_c & ~br_nxt_c;
`endif
      end
    end
  end

endmodule
